// File: rtl/cache_arbiter.sv
// Arbitrates the shared pmem line port between I-cache and D-cache misses.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin on I/D conflicts instead of fixed D-over-I.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  // state   | meaning
  // IDLE    | no transaction, arbitrate on live requests
  // SERVE_I | I-cache transaction in flight on pmem
  // SERVE_D | D-cache transaction in flight on pmem
  // DONE    | one dead cycle so the served cache can drop its request
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LINE_WIDTH-1:0]   r_wdata;
  logic [LINE_WIDTH-1:0]   r_i_rdata;
  logic [LINE_WIDTH-1:0]   r_d_rdata;
  logic                    r_wr;
  logic                    w_i_req;
  logic                    w_d_req;
  logic                    w_grant_i;
  logic                    w_grant_d;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;  // 0 = I, 1 = D

  assign w_grant_d = w_d_req && (!w_i_req || !r_last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_grant_d)      r_last_grant <= 1'b1;
      else if (w_grant_i) r_last_grant <= 1'b0;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  assign w_grant_i = w_i_req && !w_grant_d;

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    i_pmem_rdata = r_i_rdata;
    d_pmem_rdata = r_d_rdata;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next = SERVE_D;
        else if (w_grant_i) w_next = SERVE_I;
      end
      SERVE_I: begin
        pmem_read  = !r_wr;
        pmem_write = r_wr;
        if (pmem_resp) begin
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = pmem_rdata;
          w_next       = DONE;
        end
      end
      SERVE_D: begin
        pmem_read  = !r_wr;
        pmem_write = r_wr;
        if (pmem_resp) begin
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = pmem_rdata;
          w_next       = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields are captured on the grant edge so the cache may change or drop them mid-flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (r_state == IDLE) begin
        if (w_grant_d) begin
          r_addr  <= d_pmem_address;
          r_wr    <= d_pmem_write;
          r_wdata <= d_pmem_wdata;
        end else if (w_grant_i) begin
          r_addr <= i_pmem_address;
          r_wr   <= 1'b0;
        end
      end
      if (r_state == SERVE_I && pmem_resp) r_i_rdata <= pmem_rdata;
      if (r_state == SERVE_D && pmem_resp) r_d_rdata <= pmem_rdata;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $error("cache_arbiter: d_pmem_read and d_pmem_write both high, write wins");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter; honours ARB_ROUND_ROBIN_EN when defined for the build.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;
  logic m_last = 1'b0;          // last grant, 0 = I, 1 = D
  logic [LW-1:0] h_i = '0;      // last line returned to each cache
  logic [LW-1:0] h_d = '0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Arbitration rule: does D win given the live request set?
  function automatic logic pick_d(input logic ir, input logic dr);
`ifdef ARB_ROUND_ROBIN_EN
    return dr && (!ir || (m_last == 1'b0));
`else
    return dr || (ir && 1'b0);
`endif
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Memory-side driver: waits for a strobe, answers after lat cycles, returns at the DONE negedge.
  task automatic mem_txn(input int lat, input logic [LW-1:0] rd, output logic got,
                         output logic wr, output logic [AW-1:0] addr, output logic [LW-1:0] wd,
                         output logic ir, output logic dr);
    got = 1'b0; wr = 1'b0; addr = '0; wd = '0; ir = 1'b0; dr = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        got = 1'b1; wr = pmem_write; addr = pmem_address; wd = pmem_wdata;
      end
    end
    if (got) begin
      repeat (lat) @(negedge clk);
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      #1;
      ir = i_pmem_resp;
      dr = d_pmem_resp;
      @(negedge clk);
      pmem_resp = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0)
      begin errors++; $display("FAIL reset_strobes: got %b, want 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || pmem_address !== '0 || pmem_wdata !== '0 ||
        i_pmem_rdata !== '0 || d_pmem_rdata !== '0)
      begin errors++; $display("FAIL reset_release: got strobes %b addr %h, want all zero", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address); end
  endtask

  task automatic test_lone_i;
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_1040;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h1040)
      begin errors++; $display("FAIL lone_i_grant: got rd=%b wr=%b addr=%h, want 1 0 00001040", pmem_read, pmem_write, pmem_address); end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b1 || i_pmem_resp !== 1'b0)
        begin errors++; $display("FAIL lone_i_wait: got rd=%b resp=%b, want 1 0", pmem_read, i_pmem_resp); end
    end
    pmem_rdata = a5;
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== a5 || d_pmem_resp !== 1'b0 || pmem_read !== 1'b1)
      begin errors++; $display("FAIL lone_i_resp: got iresp=%b dresp=%b rd=%b data=%h", i_pmem_resp, d_pmem_resp, pmem_read, i_pmem_rdata); end
    h_i = a5;
    m_last = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0 || i_pmem_rdata !== a5)
      begin errors++; $display("FAIL lone_i_done: got rd=%b resp=%b data=%h, want 0 0 held A5", pmem_read, i_pmem_resp, i_pmem_rdata); end
    @(negedge clk);
  endtask

  task automatic test_conflict;
    logic got, wr, ir, dr, ed;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd, rd;
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = LW'(32'h1234);
    for (int n = 0; n < 2; n++) begin
      ed = pick_d(i_pmem_read, d_pmem_write);
      rd = rnd_line();
      mem_txn(2, rd, got, wr, addr, wd, ir, dr);
      checks++;
      if (!got || wr !== ed || addr !== (ed ? 32'h200 : 32'h100) || dr !== ed || ir !== !ed)
        begin errors++; $display("FAIL conflict_%0d: got strobe=%b wr=%b addr=%h iresp=%b dresp=%b, want D=%b", n, got, wr, addr, ir, dr, ed); end
      if (ed) begin
        checks++;
        if (wd !== LW'(32'h1234))
          begin errors++; $display("FAIL conflict_wdata: got %h, want 1234", wd); end
        h_d = rd; d_pmem_write = 1'b0;
      end else begin
        h_i = rd; i_pmem_read = 1'b0;
      end
      m_last = ed;
      @(negedge clk);
    end
  endtask

  task automatic test_drop;
    logic [LW-1:0] rd;
    d_pmem_read = 1'b1; d_pmem_address = 32'h300;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h300)
      begin errors++; $display("FAIL drop_grant: got rd=%b addr=%h, want 1 00000300", pmem_read, pmem_address); end
    d_pmem_read = 1'b0; d_pmem_address = 32'h400;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h300)
        begin errors++; $display("FAIL drop_hold: got rd=%b addr=%h, want 1 00000300", pmem_read, pmem_address); end
    end
    rd = rnd_line();
    pmem_rdata = rd; pmem_resp = 1'b1;
    #1;
    checks++;
    if (d_pmem_resp !== 1'b1 || d_pmem_rdata !== rd || i_pmem_resp !== 1'b0)
      begin errors++; $display("FAIL drop_resp: got dresp=%b iresp=%b data=%h", d_pmem_resp, i_pmem_resp, d_pmem_rdata); end
    h_d = rd; m_last = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0)
      begin errors++; $display("FAIL drop_idle: got rd=%b wr=%b, want 0 0", pmem_read, pmem_write); end
  endtask

  task automatic test_random;
    logic ip, dp, dw, ed, ewr;
    logic [AW-1:0] ia, da, ea;
    logic [LW-1:0] dwd, rd;
    int lat;
    ip = 1'b0; dp = 1'b0; dw = 1'b0; ia = '0; da = '0; dwd = '0;
    for (int r = 0; r < 40; r++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1'b1; ia = $urandom() & 32'hFFFF_FFE0; end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1'b1; dw = 1'($urandom_range(0, 1)); da = $urandom() & 32'hFFFF_FFE0; dwd = rnd_line();
      end
      if (!ip && !dp) begin ip = 1'b1; ia = $urandom() & 32'hFFFF_FFE0; end
      i_pmem_read = ip; i_pmem_address = ia;
      d_pmem_read = dp && !dw; d_pmem_write = dp && dw;
      d_pmem_address = da; d_pmem_wdata = dwd;
      ed = pick_d(ip, dp);
      ea = ed ? da : ia;
      ewr = ed && dw;
      lat = $urandom_range(0, 4);
      @(negedge clk);
      checks++;
      if (pmem_read !== !ewr || pmem_write !== ewr || pmem_address !== ea)
        begin errors++; $display("FAIL rnd_grant %0d: got rd=%b wr=%b addr=%h, want wr=%b addr=%h", r, pmem_read, pmem_write, pmem_address, ewr, ea); end
      if (ewr) begin
        checks++;
        if (pmem_wdata !== dwd)
          begin errors++; $display("FAIL rnd_wdata %0d: got %h, want %h", r, pmem_wdata, dwd); end
      end
      if (ed) d_pmem_address = $urandom(); else i_pmem_address = $urandom();
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        checks++;
        if (pmem_address !== ea || pmem_read !== !ewr || pmem_write !== ewr)
          begin errors++; $display("FAIL rnd_hold %0d: got rd=%b wr=%b addr=%h, want addr=%h", r, pmem_read, pmem_write, pmem_address, ea); end
      end
      rd = rnd_line();
      pmem_rdata = rd; pmem_resp = 1'b1;
      #1;
      checks++;
      if (i_pmem_resp !== !ed || d_pmem_resp !== ed)
        begin errors++; $display("FAIL rnd_route %0d: got iresp=%b dresp=%b, want D=%b", r, i_pmem_resp, d_pmem_resp, ed); end
      if (ed) h_d = rd; else h_i = rd;
      checks++;
      if (i_pmem_rdata !== h_i || d_pmem_rdata !== h_d)
        begin errors++; $display("FAIL rnd_rdata %0d: got i=%h d=%h", r, i_pmem_rdata, d_pmem_rdata); end
      @(negedge clk);
      pmem_resp = 1'b0;
      m_last = ed;
      if (ed) begin dp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      else begin ip = 1'b0; i_pmem_read = 1'b0; end
      #1;
      checks++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0)
        begin errors++; $display("FAIL rnd_done %0d: got %b, want 0000", r, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
      @(negedge clk);
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    @(negedge clk);
    if (pmem_read || pmem_write) begin
      // a pending loser was granted before being dropped; let it finish
      pmem_resp = 1'b1;
      if (i_pmem_resp) h_i = pmem_rdata;
      if (d_pmem_resp) h_d = pmem_rdata;
      @(negedge clk);
      pmem_resp = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    d_pmem_read = 1'b1; d_pmem_address = 32'h500;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1)
      begin errors++; $display("FAIL rstmid_grant: got rd=%b, want 1", pmem_read); end
    #2;
    rst = 1'b1;
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0)
      begin errors++; $display("FAIL rstmid_drop: got rd=%b dresp=%b iresp=%b, want 0 0 0", pmem_read, d_pmem_resp, i_pmem_resp); end
    d_pmem_read = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || pmem_address !== '0 || pmem_wdata !== '0 ||
        i_pmem_rdata !== '0 || d_pmem_rdata !== '0)
      begin errors++; $display("FAIL rstmid_idle: got strobes %b addr %h, want all zero", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address); end
  endtask

  task automatic test_starvation;
    logic got, wr, ir, dr, ed, i_pend;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
    logic [4:0] order, want;
    int d_left, n;
`ifdef ARB_ROUND_ROBIN_EN
    want = 5'b10111;
`else
    want = 5'b11110;
`endif
    order = '0; n = 0; d_left = 4; i_pend = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 32'hA00;
    while ((d_left > 0 || i_pend) && n < 5) begin
      d_pmem_read = (d_left > 0);
      d_pmem_address = 32'hD00 + 32'(n);
      ed = pick_d(i_pend, d_left > 0);
      mem_txn(1, rnd_line(), got, wr, addr, wd, ir, dr);
      checks++;
      if (!got || dr !== ed || ir !== !ed || addr !== (ed ? 32'hD00 + 32'(n) : 32'hA00))
        begin errors++; $display("FAIL starve_round %0d: got strobe=%b addr=%h dresp=%b, want D=%b", n, got, addr, dr, ed); end
      order[4-n] = dr;
      m_last = ed;
      if (dr) begin d_left--; d_pmem_read = 1'b0; end
      if (ir) begin i_pend = 1'b0; i_pmem_read = 1'b0; end
      n++;
      @(negedge clk);
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    checks++;
    if (order !== want)
      begin errors++; $display("FAIL starve_order: got %b, want %b (1=D)", order, want); end
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_conflict();
    test_drop();
    test_random();
    test_reset_mid();
    test_starvation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache and the data cache.
- Sits between both cache miss interfaces and pmem/L2. Grants one requester at a time and latches its request for the whole transaction.
- Returns the response to the granted cache only, then inserts one idle cycle so the cache can drop its request.
- The pipeline hazard unit sees only the per-cache resp signals, so arbitration stalls appear as ordinary cache misses.

Parameters:
- ADDR_WIDTH, 32: width of all line addresses.
- LINE_WIDTH, 256: width of cache-line read/write data.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_pmem_read  in  1  I-cache line-fill request
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  line data to I-cache
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_read  in  1  D-cache line-fill request
- d_pmem_write  in  1  D-cache writeback request
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache writeback data
- d_pmem_rdata  out  LINE_WIDTH  line data to D-cache
- d_pmem_resp  out  1  D-cache transaction complete
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  LINE_WIDTH  memory write data
- pmem_rdata  in  LINE_WIDTH  memory read data
- pmem_resp  in  1  memory transaction complete

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- States: IDLE, SERVE_I, SERVE_D, DONE. Reset forces IDLE and clears all latched fields.
- Reset values: pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0 during and immediately after reset. pmem_address and pmem_wdata are 0. Both rdata outputs are 0.
- IDLE:
  - Samples requests. A D request (read or write) goes to SERVE_D; otherwise an I request goes to SERVE_I; otherwise stay in IDLE.
  - On the transition edge, latch address and op (rd/wr), plus wdata for D.
  - No pmem strobe is driven while in IDLE.
- SERVE_x:
  - pmem_read/pmem_write, pmem_address and pmem_wdata are driven from latched registers, not from the live cache inputs.
  - Latency: a request sampled in IDLE at edge t produces the pmem strobe from cycle t+1.
  - The strobe stays asserted until pmem_resp=1.
  - When pmem_resp=1: x_pmem_resp=1 in the same cycle (combinational). x_pmem_rdata = pmem_rdata in that cycle. The strobe is still high in that cycle. Next state is DONE.
  - The non-granted resp output is always 0. The non-granted rdata output is held at its last value.
- DONE: one cycle with no strobes and no resp, then IDLE. This guarantees the served cache deasserts before re-arbitration.
- A requester dropping its request mid-transaction does not abort it. The latched transaction completes; memory cannot be cancelled.
- d_pmem_read and d_pmem_write both high is illegal. Write wins. A simulation-only assertion fires.
- Back-to-back: a requester held in IDLE waiting is granted in the IDLE cycle after DONE. Minimum spacing between two grants is 1 (DONE) + 1 (IDLE) cycles.
- Asynchronous reset mid-SERVE: strobes drop immediately, the state returns to IDLE, and no resp is issued.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register (reset 0 = I).
  - On a simultaneous I+D request in IDLE, grant the requester not granted last.
  - last_grant updates on every grant.
  - A single requester is always granted immediately.
- Undefined: fixed D-over-I priority as above. I may starve under continuous D traffic; this is accepted because D misses stall the whole pipeline.

Test Plan:
- Reset: assert rst mid-cycle with d_pmem_read=1 in SERVE_D -> pmem_read=0 immediately. After release, state is IDLE with all outputs 0.
- Lone I read: i_pmem_read=1, addr 0x0000_1040; pmem_resp arrives 5 cycles later with rdata 0xA5..A5 -> pmem_read=1 with address 0x1040 from the cycle after the request. i_pmem_resp pulses 1 cycle with rdata 0xA5..A5. Then there is 1 DONE cycle.
- Simultaneous conflict: I read 0x100 and D write 0x200 with wdata 0x1234 on the same edge -> D is served first (pmem_write=1, addr 0x200). After D's resp, DONE, then IDLE, then I is granted (pmem_read, addr 0x100). With ARB_ROUND_ROBIN_EN defined and last_grant=D, I is served first.
- Request dropped mid-flight: D read granted at 0x300, then d_pmem_read deasserts and d_pmem_address changes to 0x400 -> pmem_address stays 0x300 until pmem_resp, and d_pmem_resp still pulses.
- Illegal op: d_pmem_read=d_pmem_write=1 -> write issued and the assertion fires.
- Starvation check: D issues 4 back-to-back misses while I is held high -> without the macro, I is served after all 4. With ARB_ROUND_ROBIN_EN defined, grant order is D,I,D,D,D when I's request drops after its first service.
